// File: rtl/alu_pkg.sv
// Shared ALU definitions: condition-code encoding, NZCV bit positions and the
// ALU control opcodes used by both the ALU and the flags/writeback stage.
package alu_pkg;

    typedef enum logic [3:0] {
        COND_EQ = 4'h0,
        COND_NE = 4'h1,
        COND_CS = 4'h2,
        COND_CC = 4'h3,
        COND_MI = 4'h4,
        COND_PL = 4'h5,
        COND_VS = 4'h6,
        COND_VC = 4'h7,
        COND_HI = 4'h8,
        COND_LS = 4'h9,
        COND_GE = 4'hA,
        COND_LT = 4'hB,
        COND_GT = 4'hC,
        COND_LE = 4'hD,
        COND_AL = 4'hE,
        COND_NV = 4'hF
    } cond_e;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    localparam logic [3:0] ALU_ADD = 4'h0;
    localparam logic [3:0] ALU_SUB = 4'h1;
    localparam logic [3:0] ALU_AND = 4'h2;
    localparam logic [3:0] ALU_ORR = 4'h3;
    localparam logic [3:0] ALU_EOR = 4'h4;
    localparam logic [3:0] ALU_MOV = 4'h5;
    localparam logic [3:0] ALU_LSL = 4'h6;
    localparam logic [3:0] ALU_LSR = 4'h7;
    localparam logic [3:0] ALU_ASR = 4'h8;
    localparam logic [3:0] ALU_CMP = 4'h9;

    // Packs individual flag bits into the architectural NZCV ordering.
    function automatic logic [3:0] pack_nzcv(input logic n, input logic z,
                                             input logic c, input logic v);
        logic [3:0] f;
        f         = 4'b0000;
        f[FLAG_N] = n;
        f[FLAG_Z] = z;
        f[FLAG_C] = c;
        f[FLAG_V] = v;
        return f;
    endfunction

endpackage

// File: rtl/cond_check.sv
// Combinational evaluation of a 4-bit condition code against the NZCV flags.
module cond_check
    import alu_pkg::*;
(
    input  logic [3:0] cond_i,
    input  logic [3:0] nzcv_i,
    output logic       pass_o
);

    logic n, z, c, v;

    assign n = nzcv_i[FLAG_N];
    assign z = nzcv_i[FLAG_Z];
    assign c = nzcv_i[FLAG_C];
    assign v = nzcv_i[FLAG_V];

    always_comb begin
        pass_o = 1'b0;
        case (cond_e'(cond_i))
            COND_EQ: pass_o = z;
            COND_NE: pass_o = ~z;
            COND_CS: pass_o = c;
            COND_CC: pass_o = ~c;
            COND_MI: pass_o = n;
            COND_PL: pass_o = ~n;
            COND_VS: pass_o = v;
            COND_VC: pass_o = ~v;
            COND_HI: pass_o = c & ~z;
            COND_LS: pass_o = ~c | z;
            COND_GE: pass_o = (n == v);
            COND_LT: pass_o = (n != v);
            COND_GT: pass_o = ~z & (n == v);
            COND_LE: pass_o = z | (n != v);
            COND_AL: pass_o = 1'b1;
            COND_NV: pass_o = 1'b0;
            default: pass_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_flags_stage.sv
// Execute/writeback stage: registers the ALU result, owns the NZCV register,
// annuls writes of condition-failed instructions and counts retire/annul.
module alu_flags_stage
    import alu_pkg::*;
#(
    parameter int unsigned N     = 16,
    parameter int unsigned RA_W  = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_res,
    input  logic [3:0]       in_flags,
    input  logic [RA_W-1:0]  in_rd,
    input  logic             in_we,
    input  logic             in_setflags,
    input  logic [3:0]       in_cond,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_res,
    output logic [RA_W-1:0]  out_rd,
    output logic             out_we,
    output logic [3:0]       nzcv,
    output logic [CNT_W-1:0] cnt_retired,
    output logic [CNT_W-1:0] cnt_annulled
);

    localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             out_valid_d, out_valid_q;
    logic [N-1:0]     out_res_d, out_res_q;
    logic [RA_W-1:0]  out_rd_d, out_rd_q;
    logic             out_we_d, out_we_q;
    logic [3:0]       nzcv_d, nzcv_q;
    logic [CNT_W-1:0] cnt_ret_d, cnt_ret_q;
    logic [CNT_W-1:0] cnt_ann_d, cnt_ann_q;

    logic pass;
    logic accept;
    logic pop;

    // Evaluated on the registered flags so a setflags instruction accepted at
    // one edge is visible to the very next accepted instruction.
    cond_check u_cond_check (
        .cond_i (in_cond),
        .nzcv_i (nzcv_q),
        .pass_o (pass)
    );

    assign in_ready = ~out_valid_q | out_ready;
    assign accept   = in_valid & in_ready & ~flush;
    assign pop      = out_valid_q & out_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        out_res_d   = out_res_q;
        out_rd_d    = out_rd_q;
        out_we_d    = out_we_q;
        nzcv_d      = nzcv_q;
        cnt_ret_d   = cnt_ret_q;
        cnt_ann_d   = cnt_ann_q;

        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
            out_res_d   = in_res;
            out_rd_d    = in_rd;
            out_we_d    = in_we & pass;
            if (pass && in_setflags) begin
                nzcv_d = in_flags;
            end
            // Counters saturate rather than wrap.
            if (pass) begin
                if (cnt_ret_q != {CNT_W{1'b1}}) begin
                    cnt_ret_d = cnt_ret_q + CntOne;
                end
            end else begin
                if (cnt_ann_q != {CNT_W{1'b1}}) begin
                    cnt_ann_d = cnt_ann_q + CntOne;
                end
            end
        end else if (pop) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_res_q   <= '0;
            out_rd_q    <= '0;
            out_we_q    <= 1'b0;
            nzcv_q      <= 4'b0000;
            cnt_ret_q   <= '0;
            cnt_ann_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_res_q   <= out_res_d;
            out_rd_q    <= out_rd_d;
            out_we_q    <= out_we_d;
            nzcv_q      <= nzcv_d;
            cnt_ret_q   <= cnt_ret_d;
            cnt_ann_q   <= cnt_ann_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_res      = out_res_q;
    assign out_rd       = out_rd_q;
    assign out_we       = out_we_q;
    assign nzcv         = nzcv_q;
    assign cnt_retired  = cnt_ret_q;
    assign cnt_annulled = cnt_ann_q;

endmodule

// File: tb/tb_alu_flags_stage.sv
// Scoreboard bench for alu_flags_stage: stimulus pushes expected writeback
// entries, a negedge monitor pops and compares them when the DUT hands off.
module tb_alu_flags_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_res;
    logic [3:0]  in_flags;
    logic [3:0]  in_rd;
    logic        in_we;
    logic        in_setflags;
    logic [3:0]  in_cond;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_res;
    logic [3:0]  out_rd;
    logic        out_we;
    logic [3:0]  nzcv;
    logic [15:0] cnt_retired;
    logic [15:0] cnt_annulled;

    // Narrow-counter instance sharing the same stimulus, used for saturation.
    logic        s_in_ready;
    logic        s_out_valid;
    logic [15:0] s_out_res;
    logic [3:0]  s_out_rd;
    logic        s_out_we;
    logic [3:0]  s_nzcv;
    logic [2:0]  s_cnt_retired;
    logic [2:0]  s_cnt_annulled;

    alu_flags_stage #(.N(16), .RA_W(4), .CNT_W(16)) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_res       (in_res),
        .in_flags     (in_flags),
        .in_rd        (in_rd),
        .in_we        (in_we),
        .in_setflags  (in_setflags),
        .in_cond      (in_cond),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_res      (out_res),
        .out_rd       (out_rd),
        .out_we       (out_we),
        .nzcv         (nzcv),
        .cnt_retired  (cnt_retired),
        .cnt_annulled (cnt_annulled)
    );

    alu_flags_stage #(.N(16), .RA_W(4), .CNT_W(3)) u_sat (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (s_in_ready),
        .in_res       (in_res),
        .in_flags     (in_flags),
        .in_rd        (in_rd),
        .in_we        (in_we),
        .in_setflags  (in_setflags),
        .in_cond      (in_cond),
        .flush        (flush),
        .out_valid    (s_out_valid),
        .out_ready    (out_ready),
        .out_res      (s_out_res),
        .out_rd       (s_out_rd),
        .out_we       (s_out_we),
        .nzcv         (s_nzcv),
        .cnt_retired  (s_cnt_retired),
        .cnt_annulled (s_cnt_annulled)
    );

    typedef struct packed {
        logic [15:0] res;
        logic [3:0]  rd;
        logic        we;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;
    logic [3:0] m_nzcv = 4'b0000;
    int   m_ret = 0;
    int   m_ann = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference condition evaluation, f = {N,Z,C,V}.
    function automatic bit ref_pass(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cy;
            4'h3: return !cy;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cy && !z;
            4'h9: return !cy || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic issue(input logic [15:0] res, input logic [3:0] flags, input logic [3:0] rd,
                         input logic we, input logic sf, input logic [3:0] cond);
        bit   done;
        bit   p;
        exp_t e;
        in_valid    = 1'b1;
        in_res      = res;
        in_flags    = flags;
        in_rd       = rd;
        in_we       = we;
        in_setflags = sf;
        in_cond     = cond;
        done        = 1'b0;
        for (int b = 0; b < 20 && !done; b++) begin
            @(negedge clk);
            if (in_ready && !flush) begin
                p      = ref_pass(cond, m_nzcv);
                e.res  = res;
                e.rd   = rd;
                e.we   = we & p;
                q.push_back(e);
                if (p && sf) m_nzcv = flags;
                if (p) m_ret++;
                else m_ann++;
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: res %0h not accepted within 20 cycles", res);
        end
        in_valid = 1'b0;
    endtask

    // Writeback monitor: a flush kills the held entry, otherwise a pop is checked.
    always @(negedge clk) begin
        if (rst_n) begin
            if (flush) begin
                if (out_valid && q.size() > 0) void'(q.pop_front());
            end else if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL wb_unexpected: got res %0h with empty scoreboard", out_res);
                end else begin
                    mon_e = q.pop_front();
                    check("wb_res", {16'h0, out_res}, {16'h0, mon_e.res});
                    check("wb_rd", {28'h0, out_rd}, {28'h0, mon_e.rd});
                    check("wb_we", {31'h0, out_we}, {31'h0, mon_e.we});
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_res = '0; in_flags = '0; in_rd = '0;
        in_we = 1'b0; in_setflags = 1'b0; in_cond = '0; flush = 1'b0; out_ready = 1'b1;
        #12;
        check("rst_valid", {31'h0, out_valid}, 32'h0);
        check("rst_res", {16'h0, out_res}, 32'h0);
        check("rst_we", {31'h0, out_we}, 32'h0);
        check("rst_nzcv", {28'h0, nzcv}, 32'h0);
        check("rst_cnt", {cnt_retired, cnt_annulled}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: AL add with setflags to zero flags
        issue(16'h0005, 4'b0000, 4'd1, 1'b1, 1'b1, 4'hE);
        check("t1_valid", {31'h0, out_valid}, 32'h1);
        check("t1_res", {16'h0, out_res}, 32'h5);
        check("t1_we", {31'h0, out_we}, 32'h1);
        check("t1_nzcv", {28'h0, nzcv}, 32'h0);
        check("t1_ret", {16'h0, cnt_retired}, 32'h1);

        // 2: Z-setting SUB then back-to-back EQ and NE
        issue(16'h0000, 4'b0100, 4'd2, 1'b1, 1'b1, 4'hE);
        issue(16'h1234, 4'b0000, 4'd3, 1'b1, 1'b0, 4'h0);
        check("t2_eq_we", {31'h0, out_we}, 32'h1);
        issue(16'h5678, 4'b0000, 4'd4, 1'b1, 1'b0, 4'h1);
        check("t2_ne_we", {31'h0, out_we}, 32'h0);
        check("t2_ann", {16'h0, cnt_annulled}, 32'h1);
        check("t2_ret", {16'h0, cnt_retired}, 32'h3);
        check("t2_nzcv", {28'h0, nzcv}, 32'h4);

        // 3: stall three cycles, then pop and accept together
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        issue(16'hAAAA, 4'b0000, 4'd5, 1'b1, 1'b0, 4'hE);
        fork
            issue(16'hBBBB, 4'b0000, 4'd6, 1'b1, 1'b0, 4'hE);
            begin
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    check("t3_in_ready", {31'h0, in_ready}, 32'h0);
                    check("t3_frozen", {12'h0, out_rd, out_res}, {12'h0, 4'd5, 16'hAAAA});
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        check("t3_valid", {31'h0, out_valid}, 32'h1);
        check("t3_res", {16'h0, out_res}, 32'hBBBB);
        check("t3_ret", {16'h0, cnt_retired}, 32'h5);

        // 4: flush while an entry is held and a new one is offered
        out_ready   = 1'b0;
        in_valid    = 1'b1;
        in_res      = 16'hCCCC;
        in_flags    = 4'b1111;
        in_rd       = 4'd7;
        in_we       = 1'b1;
        in_setflags = 1'b1;
        in_cond     = 4'hE;
        flush       = 1'b1;
        @(negedge clk);
        check("t4_in_ready", {31'h0, in_ready}, 32'h0);
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        check("t4_valid", {31'h0, out_valid}, 32'h0);
        check("t4_nzcv", {28'h0, nzcv}, 32'h4);
        check("t4_cnt", {cnt_retired, cnt_annulled}, {16'h5, 16'h1});
        out_ready = 1'b1;
        @(posedge clk);
        #1;

        // 5: every condition against every flag value, plus NV with setflags
        for (int f = 0; f < 16; f++) begin
            issue(16'(f), 4'(f), 4'd8, 1'b0, 1'b1, 4'hE);
            for (int c = 0; c < 16; c++) begin
                issue({8'h00, 4'(f), 4'(c)}, 4'(15 - f), 4'(c), 1'b1, 1'b0, 4'(c));
            end
            issue(16'hFFFF, 4'(~f), 4'd9, 1'b1, 1'b1, 4'hF);
            check("t5_nv_keeps_nzcv", {28'h0, nzcv}, 32'(f));
        end
        check("t5_ret", {16'h0, cnt_retired}, 32'(m_ret));
        check("t5_ann", {16'h0, cnt_annulled}, 32'(m_ann));

        // 6: saturation on the narrow-counter copy, then async reset mid-stall
        check("t6_sat_ret", {29'h0, s_cnt_retired}, (m_ret > 7) ? 32'd7 : 32'(m_ret));
        check("t6_sat_ann", {29'h0, s_cnt_annulled}, (m_ann > 7) ? 32'd7 : 32'(m_ann));
        for (int i = 0; i < 10 && q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        check("drain_empty", 32'(q.size()), 32'h0);
        out_ready = 1'b0;
        issue(16'hDEAD, 4'b0000, 4'd10, 1'b1, 1'b0, 4'hE);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", {31'h0, out_valid}, 32'h0);
        check("t6_rst_data", {11'h0, out_we, out_rd, out_res}, 32'h0);
        check("t6_rst_nzcv", {28'h0, nzcv}, 32'h0);
        check("t6_rst_cnt", {cnt_retired, cnt_annulled}, 32'h0);
        check("t6_rst_sat", {26'h0, s_cnt_retired, s_cnt_annulled}, 32'h0);
        q.delete();
        m_nzcv = 4'b0000;
        m_ret  = 0;
        m_ann  = 0;
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("t6_post_valid", {31'h0, out_valid}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
